// File: rtl/swo_uart_core.sv
// swo_uart_core
//   Full-duplex UART engine with a programmable bit period. The transmitter
//   serializes one byte per accepted txd_syn request and, in the SWO path,
//   txd is the SWO line. The receiver is kept for reuse.
//
// Ports
//   target_clk  in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-low reset
//   bit_rate    in  16  bit period minus one, in target_clk cycles
//   data_bits   in   4  data bits per frame (clamped to 5..8)
//   stop_bits   in   2  0/1 -> one stop bit, 2/3 -> two stop bits
//   rxd         in   1  serial receive line, idle high
//   txd         out  1  serial transmit line, idle high
//   rxd_syn     out  1  received byte valid, held until rxd_ack
//   rxd_data    out  8  received byte, right-justified
//   rxd_ack     in   1  consumer acknowledge for rxd_syn
//   rxd_state   out  2  receiver state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//   txd_syn     in   1  transmit request, sampled only while idle
//   txd_data    in   8  byte to transmit, latched on acceptance
//   txd_ack     out  1  one-cycle pulse when a request is accepted
module swo_uart_core (
  input  logic        target_clk,
  input  logic        reset,
  input  logic [15:0] bit_rate,
  input  logic [3:0]  data_bits,
  input  logic [1:0]  stop_bits,
  input  logic        rxd,
  output logic        txd,
  output logic        rxd_syn,
  output logic [7:0]  rxd_data,
  input  logic        rxd_ack,
  output logic [1:0]  rxd_state,
  input  logic        txd_syn,
  input  logic [7:0]  txd_data,
  output logic        txd_ack
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE  = 2'd0, RX_START = 2'd1,
                            RX_DATA  = 2'd2, RX_STOP  = 2'd3} rx_state_t;

  function automatic logic [3:0] clamp_bits(input logic [3:0] n);
    if (n < 4'd5)      return 4'd5;
    else if (n > 4'd8) return 4'd8;
    else               return n;
  endfunction

  // ---------------------------------------------------------------- TX
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt, tx_period;
  logic [3:0]  tx_nbits, tx_bit;
  logic        tx_two_stop;
  logic [7:0]  tx_shift;
  logic        tx_tick, tx_last_data, tx_last_stop;

  assign tx_tick      = (tx_cnt == tx_period);
  assign tx_last_data = (tx_bit == tx_nbits - 4'd1);
  // In STOP tx_bit is 0 for the first stop bit and 1 for the second.
  assign tx_last_stop = (tx_bit[0] == tx_two_stop);

  always_ff @(posedge target_clk or negedge reset) begin
    if (!reset) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    txd     = 1'b1;
    case (tx_state)
      TX_IDLE:  if (txd_syn) tx_next = TX_START;
      TX_START: begin
        txd = 1'b0;
        if (tx_tick) tx_next = TX_DATA;
      end
      TX_DATA: begin
        txd = tx_shift[0];
        if (tx_tick && tx_last_data) tx_next = TX_STOP;
      end
      TX_STOP:  if (tx_tick && tx_last_stop) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Configuration is captured at acceptance so mid-frame input changes
  // cannot corrupt the frame being sent.
  always_ff @(posedge target_clk or negedge reset) begin
    if (!reset) begin
      tx_cnt      <= '0;
      tx_period   <= '0;
      tx_nbits    <= '0;
      tx_bit      <= '0;
      tx_two_stop <= 1'b0;
      tx_shift    <= '0;
      txd_ack     <= 1'b0;
    end else begin
      txd_ack <= 1'b0;
      if (tx_state == TX_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= '0;
        if (txd_syn) begin
          tx_shift    <= txd_data;
          tx_period   <= bit_rate;
          tx_nbits    <= clamp_bits(data_bits);
          tx_two_stop <= (stop_bits >= 2'd2);
          txd_ack     <= 1'b1;
        end
      end else if (tx_tick) begin
        tx_cnt <= '0;
        if (tx_state == TX_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_last_data ? 4'd0 : tx_bit + 4'd1;
        end else if (tx_state == TX_STOP) begin
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_t   rx_state, rx_next;
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic [15:0] rx_cnt, rx_period, rx_half, half_now;
  logic [3:0]  rx_nbits, rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_ferr, rx_fall, rx_tick, rx_mid, rx_last_data, rx_done;

  // floor((bit_rate+1)/2) without needing a 17-bit intermediate.
  assign half_now     = {1'b0, bit_rate[15:1]} + {15'd0, bit_rate[0]};
  assign rx_fall      = rxd_prev & ~rxd_sync;
  assign rx_tick      = (rx_cnt == rx_period);
  assign rx_mid       = (rx_cnt >= rx_half);
  assign rx_last_data = (rx_bit == rx_nbits - 4'd1);
  assign rx_done      = (rx_state == RX_STOP) && !rx_ferr && rx_tick && rxd_sync;
  assign rxd_state    = rx_state;

  always_ff @(posedge target_clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // After a framing error the receiver parks in STOP until the line is
  // seen high, so a stuck-low line cannot be mistaken for a new start bit.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_mid) rx_next = rxd_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_last_data) rx_next = RX_STOP;
      RX_STOP:  if ((rx_ferr || rx_tick) && rxd_sync) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // The edge-detect cycle counts as the first cycle of the start bit, so
  // the START counter begins at 1 and the mid-bit sample stays inside the
  // start bit even for very short bit periods.
  always_ff @(posedge target_clk or negedge reset) begin
    if (!reset) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rxd_prev  <= 1'b1;
      rx_cnt    <= '0;
      rx_period <= '0;
      rx_half   <= '0;
      rx_nbits  <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_ferr   <= 1'b0;
      rxd_syn   <= 1'b0;
      rxd_data  <= '0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;

      // A byte completing alongside an acknowledge wins.
      if (rx_done) begin
        rxd_data <= rx_shift;
        rxd_syn  <= 1'b1;
      end else if (rxd_ack) begin
        rxd_syn <= 1'b0;
      end

      case (rx_state)
        RX_IDLE: begin
          rx_ferr <= 1'b0;
          if (rx_fall) begin
            rx_cnt    <= 16'd1;
            rx_period <= bit_rate;
            rx_half   <= half_now;
            rx_nbits  <= clamp_bits(data_bits);
            rx_bit    <= '0;
            rx_shift  <= '0;
          end
        end
        RX_START: rx_cnt <= rx_mid ? 16'd0 : rx_cnt + 16'd1;
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt                <= '0;
            rx_shift[rx_bit[2:0]] <= rxd_sync;
            rx_bit                <= rx_bit + 4'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (!rx_ferr) begin
            if (rx_tick) begin
              rx_cnt <= '0;
              if (!rxd_sync) rx_ferr <= 1'b1;
            end else begin
              rx_cnt <= rx_cnt + 16'd1;
            end
          end
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_swo_uart_core.sv
// tb_swo_uart_core
//   Directed self-checking bench for swo_uart_core: reset state, TX framing
//   for two configurations, TX/RX loopback, RX glitch and framing-error
//   recovery, and reset in the middle of a transmitted frame.
module tb_swo_uart_core;

  logic        target_clk = 1'b0;
  logic        reset;
  logic [15:0] bit_rate;
  logic [3:0]  data_bits;
  logic [1:0]  stop_bits;
  logic        rxd;
  logic        txd;
  logic        rxd_syn;
  logic [7:0]  rxd_data;
  logic        rxd_ack;
  logic [1:0]  rxd_state;
  logic        txd_syn;
  logic [7:0]  txd_data;
  logic        txd_ack;

  logic        rxd_drv;
  logic        loopback;
  int          vectors = 0;
  int          miscompares = 0;
  int          syn_at;
  logic        got;

  assign rxd = loopback ? txd : rxd_drv;

  always #5 target_clk = ~target_clk;

  swo_uart_core dut (
    .target_clk (target_clk),
    .reset      (reset),
    .bit_rate   (bit_rate),
    .data_bits  (data_bits),
    .stop_bits  (stop_bits),
    .rxd        (rxd),
    .txd        (txd),
    .rxd_syn    (rxd_syn),
    .rxd_data   (rxd_data),
    .rxd_ack    (rxd_ack),
    .rxd_state  (rxd_state),
    .txd_syn    (txd_syn),
    .txd_data   (txd_data),
    .txd_ack    (txd_ack)
  );

  // Expected txd level i cycles after the accepting clock edge (i >= 1).
  function automatic logic exp_txd(input int i, input logic [7:0] d,
                                   input int nbits, input int p);
    int idx;
    idx = (i - 1) / p;
    if (idx == 0)          return 1'b0;
    else if (idx <= nbits) return d[idx-1];
    else                   return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one 8N1 frame on rxd at 16 cycles per bit; the line is left at
  // the stop level when the task returns.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_level);
    rxd_drv = 1'b0;
    repeat (16) @(negedge target_clk);
    for (int b = 0; b < 8; b++) begin
      rxd_drv = data[b];
      repeat (16) @(negedge target_clk);
    end
    rxd_drv = stop_level;
    repeat (16) @(negedge target_clk);
  endtask

  initial begin
    reset = 1'b0; bit_rate = 16'd15; data_bits = 4'd8; stop_bits = 2'd0;
    rxd_drv = 1'b1; loopback = 1'b0; rxd_ack = 1'b0;
    txd_syn = 1'b0; txd_data = 8'h00;

    // Reset state, with a request toggled while reset is held
    repeat (2) @(negedge target_clk);
    txd_syn = 1'b1; txd_data = 8'h5A;
    repeat (2) @(negedge target_clk);
    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_txd_ack", txd_ack, 0);
    checkOutput("rst_rxd_syn", rxd_syn, 0);
    checkOutput("rst_rxd_data", rxd_data, 8'h00);
    checkOutput("rst_rxd_state", rxd_state, 0);
    txd_syn = 1'b0;
    @(negedge target_clk);
    reset = 1'b1;
    repeat (3) @(negedge target_clk);
    checkOutput("post_rst_txd", txd, 1);
    checkOutput("post_rst_ack", txd_ack, 0);

    // TX 8N1, P=16, 0xA5, with a second request mid-frame
    txd_data = 8'hA5; txd_syn = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge target_clk);
      checkOutput("tx8n1_txd", txd, exp_txd(i, 8'hA5, 8, 16));
      checkOutput("tx8n1_ack", txd_ack, (i == 1));
      if (i == 1)  txd_syn = 1'b0;
      if (i == 50) txd_syn = 1'b1;
      if (i == 51) txd_syn = 1'b0;
    end

    // TX 7 data bits, 2 stop bits, P=4: 40-cycle frame, then the held
    // request is accepted after one idle cycle
    bit_rate = 16'd3; data_bits = 4'd7; stop_bits = 2'd2;
    txd_data = 8'hFF; txd_syn = 1'b1;
    for (int i = 1; i <= 44; i++) begin
      @(negedge target_clk);
      checkOutput("txcfg_txd", txd, (i <= 4 || i >= 42) ? 0 : 1);
      checkOutput("txcfg_ack", txd_ack, (i == 1 || i == 42));
      if (i == 42) txd_syn = 1'b0;
    end
    repeat (50) @(negedge target_clk);

    // Loopback 0x3C at P=16
    bit_rate = 16'd15; data_bits = 4'd8; stop_bits = 2'd0;
    loopback = 1'b1; txd_data = 8'h3C; txd_syn = 1'b1;
    syn_at = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge target_clk);
      if (i == 1) txd_syn = 1'b0;
      if (i == 60) checkOutput("lb_state_data", rxd_state, 2);
      if (rxd_syn && syn_at == 0) syn_at = i;
    end
    checkOutput("lb_syn_window", (syn_at > 144 && syn_at <= 170), 1);
    checkOutput("lb_data", rxd_data, 8'h3C);
    checkOutput("lb_syn_held", rxd_syn, 1);
    checkOutput("lb_state_idle", rxd_state, 0);
    rxd_ack = 1'b1;
    @(negedge target_clk);
    rxd_ack = 1'b0;
    checkOutput("lb_ack_clear", rxd_syn, 0);
    checkOutput("lb_data_kept", rxd_data, 8'h3C);
    loopback = 1'b0;

    // 4-cycle low glitch
    repeat (4) @(negedge target_clk);
    rxd_drv = 1'b0;
    repeat (3) @(negedge target_clk);
    checkOutput("glitch_start", rxd_state, 1);
    @(negedge target_clk);
    rxd_drv = 1'b1;
    repeat (10) @(negedge target_clk);
    checkOutput("glitch_idle", rxd_state, 0);
    checkOutput("glitch_no_syn", rxd_syn, 0);

    // Framing error then a valid 0x55
    repeat (16) @(negedge target_clk);
    applyStimulus(8'hF0, 1'b0);
    checkOutput("fe_state_stop", rxd_state, 3);
    checkOutput("fe_no_syn", rxd_syn, 0);
    rxd_drv = 1'b1;
    repeat (6) @(negedge target_clk);
    checkOutput("fe_recover_idle", rxd_state, 0);
    checkOutput("fe_still_no_syn", rxd_syn, 0);
    repeat (16) @(negedge target_clk);
    applyStimulus(8'h55, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (rxd_syn) got = 1'b1;
      else @(negedge target_clk);
    end
    checkOutput("fe_next_syn", got, 1);
    checkOutput("fe_next_data", rxd_data, 8'h55);

    // Reset in the middle of a TX data bit, then a clean 0x81 frame
    repeat (20) @(negedge target_clk);
    txd_data = 8'h00; txd_syn = 1'b1;
    @(negedge target_clk);
    txd_syn = 1'b0;
    repeat (39) @(negedge target_clk);
    checkOutput("mf_txd_low", txd, 0);
    reset = 1'b0;
    #1;
    checkOutput("mf_txd_reset", txd, 1);
    checkOutput("mf_rxd_syn_reset", rxd_syn, 0);
    checkOutput("mf_rxd_data_reset", rxd_data, 8'h00);
    @(negedge target_clk);
    reset = 1'b1;
    repeat (2) @(negedge target_clk);
    txd_data = 8'h81; txd_syn = 1'b1;
    for (int i = 1; i <= 170; i++) begin
      @(negedge target_clk);
      checkOutput("mf_frame_txd", txd, exp_txd(i, 8'h81, 8, 16));
      checkOutput("mf_frame_ack", txd_ack, (i == 1));
      if (i == 1) txd_syn = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/swo_uart_core.md
Name: swo_uart_core

Overview:
- Configurable full-duplex UART engine: one transmitter and one receiver, both running on a single clock with a programmable bit period.
- Used as the SWO (single-wire output) serializer: the trace generator pushes one byte per txd_syn pulse, and txd becomes the SWO line.
- The receiver is present for reuse; in the SWO path it is tied idle (rxd=1, rxd_ack=0).

Parameters:
- None. All configuration is through the input ports.

Ports:
- target_clk  in  1  system clock; all logic is clocked on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- bit_rate  in  16  bit period minus one, in target_clk cycles.
- data_bits  in  4  data bits per frame; legal range 5..8.
- stop_bits  in  2  number of stop bits; 0 or 1 gives 1 stop bit, 2 or 3 gives 2 stop bits.
- rxd  in  1  serial receive line; idle level high.
- txd  out  1  serial transmit line; idle level high.
- rxd_syn  out  1  received byte valid; level signal held until acknowledged.
- rxd_data  out  8  received byte, right-justified; unused upper bits are 0.
- rxd_ack  in  1  consumer acknowledge; clears rxd_syn.
- rxd_state  out  2  receiver state: 0 IDLE, 1 START, 2 DATA, 3 STOP.
- txd_syn  in  1  transmit request; sampled only when the transmitter is idle.
- txd_data  in  8  byte to transmit; latched on an accepted request.
- txd_ack  out  1  one-cycle pulse when a request is accepted.

Behaviour:
- Reset (async assert, sync release): txd=1, txd_ack=0, rxd_syn=0, rxd_data=0, rxd_state=0; all counters cleared. Assertion mid-frame aborts both directions immediately.
- Bit period P = bit_rate+1 cycles; bit_rate=0 gives P=1.
- data_bits values below 5 are treated as 5; values above 8 are treated as 8.
- Configuration inputs are sampled at frame start and held for the whole frame.
- Bit order is LSB first on both TX and RX.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: txd=1. If txd_syn=1 at a clock edge, latch txd_data and pulse txd_ack for that one cycle. txd drives 0 from the next cycle.
  - START: txd=0 for P cycles.
  - DATA: data_bits bits, P cycles each.
  - STOP: txd=1 for P×(stop bits) cycles.
  - Frame length = P×(1+data_bits+stop bits) cycles. Example: P=16, 8N1 gives 160 cycles.
  - txd_syn is ignored while busy; no queueing.
  - A request present in the cycle STOP ends is accepted from IDLE on the following cycle (one idle cycle minimum between frames).
- RX:
  - rxd passes through a 2-flop synchronizer, initialised to 1.
  - IDLE: a synchronized falling edge moves to START.
  - START: wait floor(P/2) cycles, then resample. If rxd=1 (glitch), return to IDLE. Otherwise go to DATA.
  - DATA: sample every P cycles at mid-bit, shifting into the data register LSB first.
  - STOP: sample once after P cycles.
    - If rxd=1: load rxd_data, set rxd_syn=1, return to IDLE.
    - If rxd=0 (framing error): discard the byte, leave rxd_syn unchanged, return to IDLE only after rxd has been seen high.
  - Only the first stop bit is checked; extra stop bits are treated as idle time.
- rxd_syn stays high until rxd_ack=1 on a clock edge, which clears it the next cycle. If a new byte completes in the same cycle as rxd_ack, the new byte wins: rxd_syn stays 1 and rxd_data is updated. A new byte while rxd_syn=1 overwrites rxd_data (no overrun flag).
- rxd_state reflects the current RX FSM state.
- TX and RX operate fully independently.

Test Plan:
- Reset check: hold reset=0, then release -> txd=1, rxd_syn=0, rxd_data=0x00, rxd_state=0; toggling txd_syn during reset is ignored.
- TX 8N1: bit_rate=15, txd_data=0xA5, 1-cycle txd_syn pulse.
  - txd_ack pulses once.
  - txd reads 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop); each level lasts 16 cycles, 160 cycles total.
  - A second txd_syn mid-frame produces no ack and no extra frame.
- TX config: bit_rate=3, data_bits=7, stop_bits=2, txd_data=0xFF -> frame of 10 bits × 4 = 40 cycles. Bit 7 is not sent; line is high after the start bit.
- Loopback: connect txd to rxd, bit_rate=15, send 0x3C -> rxd_syn=1 with rxd_data=0x3C within 1 bit period after the stop-bit sample. rxd_ack clears rxd_syn on the next cycle.
- RX errors:
  - A 4-cycle low glitch on rxd -> returns to IDLE with no rxd_syn.
  - A frame whose stop bit is forced low -> no rxd_syn; the receiver recovers and a following valid 0x55 is received correctly.
- Reset mid-frame: assert reset during a TX data bit -> txd=1 immediately. After release, a new 0x81 request transmits a complete, correct frame.
